// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM memory port arbiter.
// State encodings are fixed at 3 bits so they stay stable across revisions.
package mem_port_arbiter_pkg;

   localparam int unsigned AddrWDef      = 32;
   localparam int unsigned DataWDef      = 32;
   localparam int unsigned TimeoutCycDef = 255;
   localparam int unsigned StarveMaxDef  = 4;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StDReq  = 3'd1,
      StDWait = 3'd2,
      StIReq  = 3'd3,
      StIWait = 3'd4
   } arb_state_e;

   function automatic logic is_req_state(input arb_state_e s);
      return (s == StDReq) || (s == StIReq);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the pipeline, the arbiter and the single-port memory.
// The arbiter takes the slave view; the surrounding pipeline/memory takes the master view.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned AddrW = AddrWDef,
   parameter int unsigned DataW = DataWDef
);

   // Instruction fetch side
   logic             if_req;
   logic [AddrW-1:0] if_addr;
   logic             if_flush;
   logic [DataW-1:0] if_data_r;
   logic             if_valid;

   // Load/store side
   logic             mem_read;
   logic             mem_write;
   logic [AddrW-1:0] mem_addr;
   logic [DataW-1:0] mem_data_w;
   logic [DataW-1:0] mem_data_r;
   logic             mem_valid;

   // Pipeline control
   logic             stall_if;
   logic             stall_mem;

   // Memory port
   logic             ram_req;
   logic             ram_we;
   logic [AddrW-1:0] ram_addr;
   logic [DataW-1:0] ram_data_w;
   logic             ram_ack;
   logic             ram_rvalid;
   logic [DataW-1:0] ram_data_r;

   logic             err_timeout;

   modport slave (
      input  if_req, if_addr, if_flush,
      output if_data_r, if_valid,
      input  mem_read, mem_write, mem_addr, mem_data_w,
      output mem_data_r, mem_valid,
      output stall_if, stall_mem,
      output ram_req, ram_we, ram_addr, ram_data_w,
      input  ram_ack, ram_rvalid, ram_data_r,
      output err_timeout
   );

   modport master (
      output if_req, if_addr, if_flush,
      input  if_data_r, if_valid,
      output mem_read, mem_write, mem_addr, mem_data_w,
      input  mem_data_r, mem_valid,
      input  stall_if, stall_mem,
      input  ram_req, ram_we, ram_addr, ram_data_w,
      output ram_ack, ram_rvalid, ram_data_r,
      input  err_timeout
   );

endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// Per-state watchdog: reloads on state entry, counts while enabled, flags expiry.
// The count is the number of cycles spent in the current state, including this one.
module mem_port_arbiter_timeout #(
   parameter int unsigned MaxCyc = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam int unsigned CntW = $clog2(MaxCyc + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign expire = en & (cnt_q == CntW'(MaxCyc));

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CntW'(1);
      end else if (en && !expire) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one access
// in flight; load/store wins unless fetch has been passed over StarveMax times in a row.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned AddrW      = AddrWDef,
   parameter int unsigned DataW      = DataWDef,
   parameter int unsigned TimeoutCyc = TimeoutCycDef,
   parameter int unsigned StarveMax  = StarveMaxDef
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned StarveW = $clog2(StarveMax + 1);

   arb_state_e         state_q, state_d;
   logic [StarveW-1:0] starve_q, starve_d;
   logic               discard_q, discard_d;
   logic [AddrW-1:0]   addr_q, addr_d;
   logic               we_q, we_d;
   logic [DataW-1:0]   wdata_q, wdata_d;
   logic               ram_req_q, ram_req_d;
   logic               if_valid_q, if_valid_d;
   logic [DataW-1:0]   if_data_q, if_data_d;
   logic               mem_valid_q, mem_valid_d;
   logic [DataW-1:0]   mem_data_q, mem_data_d;
   logic               err_q, err_d;

   logic mem_pend, if_pend, retire, if_forced, kill;
   logic if_valid_out;
   logic tmr_load, tmr_en, expire;

   assign mem_pend  = bus.mem_read | bus.mem_write;
   assign if_pend   = bus.if_req;
   // A completing requester still holds its request this cycle; do not re-grant it.
   assign retire    = if_valid_q | mem_valid_q;
   assign if_forced = if_pend & (starve_q == StarveW'(StarveMax));
   assign kill      = discard_q | bus.if_flush;

   assign tmr_load = (state_d != state_q);
   assign tmr_en   = (state_q != StIdle);

   mem_port_arbiter_timeout #(
      .MaxCyc(TimeoutCyc)
   ) u_timeout (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .en    (tmr_en),
      .expire(expire)
   );

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      discard_d   = discard_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      if_valid_d  = 1'b0;
      if_data_d   = if_data_q;
      mem_valid_d = 1'b0;
      mem_data_d  = mem_data_q;
      err_d       = err_q;

      unique case (state_q)
         StIdle: begin
            discard_d = 1'b0;
            if (!retire) begin
               if (mem_pend && !if_forced) begin
                  state_d = StDReq;
                  addr_d  = bus.mem_addr;
                  we_d    = bus.mem_write;
                  wdata_d = bus.mem_data_w;
                  if (if_pend) begin
                     starve_d = starve_q + 1'b1;
                  end
               end else if (if_pend) begin
                  state_d  = StIReq;
                  addr_d   = bus.if_addr;
                  we_d     = 1'b0;
                  starve_d = '0;
               end
            end
         end

         StDReq: begin
            if (bus.ram_ack) begin
               if (we_q) begin
                  state_d     = StIdle;
                  mem_valid_d = 1'b1;
               end else begin
                  state_d = StDWait;
               end
            end else if (expire) begin
               state_d     = StIdle;
               err_d       = 1'b1;
               mem_valid_d = 1'b1;
               mem_data_d  = '0;
            end
         end

         StDWait: begin
            if (bus.ram_rvalid) begin
               state_d     = StIdle;
               mem_valid_d = 1'b1;
               mem_data_d  = bus.ram_data_r;
            end else if (expire) begin
               state_d     = StIdle;
               err_d       = 1'b1;
               mem_valid_d = 1'b1;
               mem_data_d  = '0;
            end
         end

         StIReq: begin
            if (bus.if_flush) begin
               discard_d = 1'b1;
            end
            if (bus.ram_ack) begin
               state_d = StIWait;
            end else if (expire) begin
               state_d = StIdle;
               err_d   = 1'b1;
               if (!kill) begin
                  if_valid_d = 1'b1;
                  if_data_d  = '0;
               end
            end
         end

         StIWait: begin
            if (bus.if_flush) begin
               discard_d = 1'b1;
            end
            // A killed fetch still consumes its response, it just never reaches IF.
            if (bus.ram_rvalid) begin
               state_d = StIdle;
               if (!kill) begin
                  if_valid_d = 1'b1;
                  if_data_d  = bus.ram_data_r;
               end
            end else if (expire) begin
               state_d = StIdle;
               err_d   = 1'b1;
               if (!kill) begin
                  if_valid_d = 1'b1;
                  if_data_d  = '0;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      if (!if_pend) begin
         starve_d = '0;
      end

      ram_req_d = is_req_state(state_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         starve_q    <= '0;
         discard_q   <= 1'b0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         ram_req_q   <= 1'b0;
         if_valid_q  <= 1'b0;
         if_data_q   <= '0;
         mem_valid_q <= 1'b0;
         mem_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         discard_q   <= discard_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         ram_req_q   <= ram_req_d;
         if_valid_q  <= if_valid_d;
         if_data_q   <= if_data_d;
         mem_valid_q <= mem_valid_d;
         mem_data_q  <= mem_data_d;
         err_q       <= err_d;
      end
   end

   assign if_valid_out   = if_valid_q & ~bus.if_flush;
   assign bus.if_valid   = if_valid_out;
   assign bus.if_data_r  = if_data_q;
   assign bus.mem_valid  = mem_valid_q;
   assign bus.mem_data_r = mem_data_q;

   assign bus.stall_if   = bus.if_req & ~if_valid_out;
   assign bus.stall_mem  = mem_pend & ~mem_valid_q;

   assign bus.ram_req    = ram_req_q;
   assign bus.ram_we     = we_q;
   assign bus.ram_addr   = addr_q;
   assign bus.ram_data_w = wdata_q;

   assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory requests and
// responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int unsigned AddrW      = 32;
   localparam int unsigned DataW      = 32;
   localparam int unsigned TimeoutCyc = 255;
   localparam int unsigned StarveMax  = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } req_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AddrW(AddrW), .DataW(DataW)) bus ();

   mem_port_arbiter #(
      .AddrW     (AddrW),
      .DataW     (DataW),
      .TimeoutCyc(TimeoutCyc),
      .StarveMax (StarveMax)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_vec = 0;
   int n_err = 0;

   req_t        exp_req_q[$];
   logic [31:0] exp_if_q[$];
   logic [31:0] exp_mem_q[$];

   int ack_delay = 0;
   int rd_delay  = 0;
   bit ack_block = 1'b0;

   function automatic logic [31:0] ram_model(input logic [31:0] a);
      if (a == 32'h0040_0000) return 32'h2408_0005;
      return a ^ 32'h5A5A_5A5A;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic req_t mk_req(input logic [31:0] a, input logic we, input logic [31:0] d);
      req_t r;
      r.addr  = a;
      r.we    = we;
      r.wdata = d;
      return r;
   endfunction

   // Memory responder: ack after ack_delay cycles of Req, read data rd_delay cycles later.
   initial begin : responder
      int          wait_cnt;
      int          rd_wait;
      bit          rd_pend;
      logic [31:0] rd_addr;
      wait_cnt = 0;
      rd_wait  = 0;
      rd_pend  = 1'b0;
      rd_addr  = '0;
      bus.ram_ack    = 1'b0;
      bus.ram_rvalid = 1'b0;
      bus.ram_data_r = '0;
      forever begin
         @(negedge clk);
         bus.ram_ack    = 1'b0;
         bus.ram_rvalid = 1'b0;
         if (rst) begin
            rd_pend  = 1'b0;
            wait_cnt = 0;
         end else if (rd_pend) begin
            if (rd_wait == 0) begin
               bus.ram_rvalid = 1'b1;
               bus.ram_data_r = ram_model(rd_addr);
               rd_pend        = 1'b0;
            end else begin
               rd_wait--;
            end
         end else if (bus.ram_req && !ack_block) begin
            if (wait_cnt >= ack_delay) begin
               bus.ram_ack = 1'b1;
               wait_cnt    = 0;
               if (!bus.ram_we) begin
                  rd_pend = 1'b1;
                  rd_addr = bus.ram_addr;
                  rd_wait = rd_delay;
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin : monitor
      bit          req_seen;
      req_t        r;
      logic [31:0] e;
      req_seen = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            req_seen = 1'b0;
         end else begin
            if (bus.ram_req && !req_seen) begin
               if (exp_req_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL ram_req: unexpected request addr 0x%08h, expected none",
                           bus.ram_addr);
               end else begin
                  r = exp_req_q.pop_front();
                  check("ram_addr", bus.ram_addr, r.addr);
                  check("ram_we", 32'(bus.ram_we), 32'(r.we));
                  if (r.we) check("ram_data_w", bus.ram_data_w, r.wdata);
               end
            end
            req_seen = bus.ram_req;
            if (bus.if_valid) begin
               if (exp_if_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL if_valid: unexpected pulse data 0x%08h, expected none",
                           bus.if_data_r);
               end else begin
                  e = exp_if_q.pop_front();
                  check("if_data_r", bus.if_data_r, e);
               end
            end
            if (bus.mem_valid) begin
               if (exp_mem_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL mem_valid: unexpected pulse data 0x%08h, expected none",
                           bus.mem_data_r);
               end else begin
                  e = exp_mem_q.pop_front();
                  check("mem_data_r", bus.mem_data_r, e);
               end
            end
         end
      end
   end

   // Single fetch from an idle arbiter: Valid three cycles after the request appears.
   task automatic do_fetch(input logic [31:0] a);
      int lat;
      bit stall_ok;
      exp_req_q.push_back(mk_req(a, 1'b0, 32'h0));
      exp_if_q.push_back(ram_model(a));
      bus.if_addr = a;
      bus.if_req  = 1'b1;
      #1;
      lat      = 0;
      stall_ok = 1'b1;
      while (!bus.if_valid && lat < 20) begin
         if (!bus.stall_if) stall_ok = 1'b0;
         step();
         lat++;
      end
      check("fetch_latency", lat, 32'd3);
      check("stall_if_waiting", 32'(stall_ok), 32'd1);
      check("stall_if_on_valid", 32'(bus.stall_if), 32'd0);
      bus.if_req = 1'b0;
      step();
   endtask

   initial begin : main
      int cyc, mem_cyc, if_cyc, req_len, n_mem, mem_before_if;
      bit we_ok, saw, stall_ok;

      bus.if_req     = 1'b0;
      bus.if_addr    = '0;
      bus.if_flush   = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_data_w = '0;

      // Reset state
      #2 rst = 1'b1;
      repeat (3) step();
      check("rst_ram_req", 32'(bus.ram_req), 32'd0);
      check("rst_if_valid", 32'(bus.if_valid), 32'd0);
      check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
      check("rst_mem_data_r", bus.mem_data_r, 32'd0);
      check("rst_if_data_r", bus.if_data_r, 32'd0);
      check("rst_err", 32'(bus.err_timeout), 32'd0);
      rst = 1'b0;
      step();
      check("idle_stall_if", 32'(bus.stall_if), 32'd0);
      check("idle_stall_mem", 32'(bus.stall_mem), 32'd0);

      // IF only
      do_fetch(32'h0040_0000);

      // IF and load in the same cycle: load first, fetch granted after the load retires
      exp_req_q.push_back(mk_req(32'h1000_0000, 1'b0, 32'h0));
      exp_req_q.push_back(mk_req(32'h0040_0004, 1'b0, 32'h0));
      exp_mem_q.push_back(ram_model(32'h1000_0000));
      exp_if_q.push_back(ram_model(32'h0040_0004));
      bus.mem_addr = 32'h1000_0000;
      bus.mem_read = 1'b1;
      bus.if_addr  = 32'h0040_0004;
      bus.if_req   = 1'b1;
      cyc = 0; mem_cyc = -1; if_cyc = -1;
      while ((mem_cyc < 0 || if_cyc < 0) && cyc < 40) begin
         step();
         cyc++;
         if (bus.mem_valid && mem_cyc < 0) begin
            mem_cyc      = cyc;
            bus.mem_read = 1'b0;
         end
         if (bus.if_valid && if_cyc < 0) begin
            if_cyc     = cyc;
            bus.if_req = 1'b0;
         end
      end
      check("both_mem_cycle", mem_cyc, 32'd3);
      check("both_if_cycle", if_cyc, 32'd7);
      step();

      // Store with Ack three cycles late; load data from before is held
      ack_delay = 3;
      exp_req_q.push_back(mk_req(32'h1000_0004, 1'b1, 32'hDEAD_BEEF));
      exp_mem_q.push_back(ram_model(32'h1000_0000));
      bus.mem_addr   = 32'h1000_0004;
      bus.mem_data_w = 32'hDEAD_BEEF;
      bus.mem_write  = 1'b1;
      #1;
      cyc = 0; req_len = 0; we_ok = 1'b1; stall_ok = 1'b1;
      while (!bus.mem_valid && cyc < 40) begin
         if (!bus.stall_mem) stall_ok = 1'b0;
         step();
         cyc++;
         if (bus.ram_req) begin
            req_len++;
            if (!bus.ram_we) we_ok = 1'b0;
         end
      end
      check("store_valid_cycle", cyc, 32'd5);
      check("store_req_len", req_len, 32'd4);
      check("store_we_held", 32'(we_ok), 32'd1);
      check("store_stall_mem", 32'(stall_ok), 32'd1);
      bus.mem_write = 1'b0;
      ack_delay     = 0;
      step();

      // Flush while the fetch waits for data
      rd_delay = 2;
      exp_req_q.push_back(mk_req(32'h0040_0008, 1'b0, 32'h0));
      bus.if_addr = 32'h0040_0008;
      bus.if_req  = 1'b1;
      step();
      step();
      check("flush_fetch_acked", 32'(bus.ram_req), 32'd0);
      bus.if_flush = 1'b1;
      bus.if_req   = 1'b0;
      step();
      bus.if_flush = 1'b0;
      saw = 1'b0;
      repeat (6) begin
         if (bus.if_valid) saw = 1'b1;
         step();
      end
      check("flush_no_if_valid", 32'(saw), 32'd0);
      rd_delay = 0;
      do_fetch(32'h0040_0010);
      check("flush_no_err", 32'(bus.err_timeout), 32'd0);

      // Five back-to-back loads with IF waiting: the fifth grant goes to IF
      for (int k = 0; k < 4; k++) begin
         exp_req_q.push_back(mk_req(32'h1000_0100 + 32'(4 * k), 1'b0, 32'h0));
      end
      exp_req_q.push_back(mk_req(32'h0040_0020, 1'b0, 32'h0));
      exp_req_q.push_back(mk_req(32'h1000_0110, 1'b0, 32'h0));
      for (int k = 0; k < 5; k++) begin
         exp_mem_q.push_back(ram_model(32'h1000_0100 + 32'(4 * k)));
      end
      exp_if_q.push_back(ram_model(32'h0040_0020));
      bus.if_addr  = 32'h0040_0020;
      bus.if_req   = 1'b1;
      bus.mem_addr = 32'h1000_0100;
      bus.mem_read = 1'b1;
      cyc = 0; n_mem = 0; mem_before_if = -1;
      while ((n_mem < 5 || mem_before_if < 0) && cyc < 100) begin
         step();
         cyc++;
         if (bus.mem_valid) begin
            n_mem++;
            if (n_mem < 5) bus.mem_addr = 32'h1000_0100 + 32'(4 * n_mem);
            else bus.mem_read = 1'b0;
         end
         if (bus.if_valid && mem_before_if < 0) begin
            mem_before_if = n_mem;
            bus.if_req    = 1'b0;
         end
      end
      check("starve_loads_done", n_mem, 32'd5);
      check("starve_loads_before_if", mem_before_if, 32'd4);
      step();

      // Ack never comes: abort after TimeoutCyc cycles of Req
      ack_block = 1'b1;
      exp_req_q.push_back(mk_req(32'h1000_0200, 1'b0, 32'h0));
      exp_mem_q.push_back(32'h0);
      bus.mem_addr = 32'h1000_0200;
      bus.mem_read = 1'b1;
      cyc = 0; req_len = 0;
      while (!bus.mem_valid && cyc < 400) begin
         step();
         cyc++;
         if (bus.ram_req) req_len++;
      end
      check("timeout_req_len", req_len, TimeoutCyc);
      check("timeout_valid_cycle", cyc, TimeoutCyc + 1);
      check("timeout_err_set", 32'(bus.err_timeout), 32'd1);
      bus.mem_read = 1'b0;
      ack_block    = 1'b0;
      repeat (3) step();
      check("timeout_err_sticky", 32'(bus.err_timeout), 32'd1);
      do_fetch(32'h0040_0030);
      check("timeout_err_after_fetch", 32'(bus.err_timeout), 32'd1);
      rst = 1'b1;
      step();
      check("rst_clears_err", 32'(bus.err_timeout), 32'd0);
      check("rst_clears_if_data", bus.if_data_r, 32'd0);
      rst = 1'b0;
      repeat (3) step();

      check("left_req", exp_req_q.size(), 32'd0);
      check("left_if", exp_if_q.size(), 32'd0);
      check("left_mem", exp_mem_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
